// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared encodings for the multicycle RISC-V controller: FSM state enum,
// opcode constants, ALUOp codes, ALUControl codes and the operand/result
// select encodings driven onto the datapath muxes.
//
// Configuration macro: JALR_SUPPORT_EN
//   When defined, the JALRADR/JALRLINK states exist and opcode 1100111 (jalr)
//   is a supported instruction. When undefined, jalr decodes as illegal.
// -----------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BEQ,
        JAL
`ifdef JALR_SUPPORT_EN
        ,
        JALRADR,
        JALRLINK
`endif
    } state_e;

    // Opcodes (instruction bits [6:0])
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // Coarse ALU request from the FSM; ALUOP_FUNCT defers to funct3/funct7.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // True for every opcode the FSM has a path for; anything else is illegal.
    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: return 1'b1;
`ifdef JALR_SUPPORT_EN
            OP_JALR: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_aludec.sv
// -----------------------------------------------------------------------------
// aludec
// Combinational ALU decoder: turns the FSM's coarse ALUOp plus the
// instruction's funct fields into the 3-bit ALUControl code.
//
// Ports:
//   op5_i         in  1  opcode bit 5 (1 = R-type, 0 = I-type ALU)
//   funct3_i      in  3  instruction bits [14:12]
//   funct7b5_i    in  1  instruction bit 30
//   alu_op_i      in  2  ALUOp from the FSM
//   alu_control_o out 3  ALU operation select
// -----------------------------------------------------------------------------
module aludec
    import riscv_pkg::*;
(
    input  logic    op5_i,
    input  logic [2:0] funct3_i,
    input  logic    funct7b5_i,
    input  alu_op_e alu_op_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would otherwise infer a latch.
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // funct7b5 only means "sub" for R-type; addi reuses the bit
                    // as part of its immediate, so op[5] must qualify it.
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Moore FSM control unit for a multicycle RV32I subset (lw, sw, R-type,
// I-type ALU, beq, jal, and optionally jalr). Owns the state register,
// per-state datapath controls, ImmSrc decode and PCWrite composition; the
// ALUControl decode lives in the aludec sub-module.
//
// Configuration macro: JALR_SUPPORT_EN (adds JALRADR/JALRLINK path for jalr).
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   op, funct3, funct7b5, Zero   instruction fields and ALU zero flag
//   ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc   datapath mux selects
//   IRWrite, PCWrite, RegWrite, MemWrite          write enables
//   ALUControl      ALU operation
//   Illegal         one-cycle pulse in DECODE for an unsupported opcode
// -----------------------------------------------------------------------------
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [2:0] ALUControl,
    output logic       Illegal
);

    state_e  state_q, state_d;
    alu_op_e alu_op;
    logic    pc_update;
    logic    branch;

    // NOTE: reset is sampled on the clock edge (synchronous), so it only takes
    // effect at the next rising edge; state uses non-blocking assignment so
    // every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECR;
                    OP_ITYPE:     state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
`ifdef JALR_SUPPORT_EN
                    OP_JALR:      state_d = JALRADR;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            // Only lw and sw reach MEMADR; op[5] tells them apart.
            MEMADR:   state_d = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = MEMWB;
            EXECR, EXECI, JAL: state_d = ALUWB;
`ifdef JALR_SUPPORT_EN
            JALRADR:  state_d = JALRLINK;
            JALRLINK: state_d = ALUWB;
`endif
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_REG;
        alu_op    = ALUOP_ADD;
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        Illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                pc_update = 1'b1;
            end
            DECODE: begin
                // Precompute the branch target from OldPC + imm while decoding.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                Illegal = !op_supported(op);
            end
            MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
            end
            EXECI: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            EXECR: begin
                ALUSrcA = SRCA_REG;
                alu_op  = ALUOP_FUNCT;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            ALUWB: begin
                RegWrite = 1'b1;
            end
            BEQ: begin
                ALUSrcA = SRCA_REG;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            JAL: begin
                // Link value OldPC+4 is computed while PC takes the target in ALUOut.
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
`ifdef JALR_SUPPORT_EN
            JALRADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
            end
            JALRLINK: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign PCWrite = pc_update | (branch & Zero);

    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_LW, OP_ITYPE, OP_JALR: ImmSrc = IMM_I;
            OP_SW:                    ImmSrc = IMM_S;
            OP_BEQ:                   ImmSrc = IMM_B;
            OP_JAL:                   ImmSrc = IMM_J;
            default:                  ImmSrc = IMM_I;
        endcase
    end

    aludec u_aludec (
        .op5_i         (op[5]),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .alu_op_i      (alu_op),
        .alu_control_o (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Self-checking bench: a table of per-instruction summaries (latency, pulse
// counts, decoded fields), directed multi-cycle corner cases, and random
// instruction streams compared cycle by cycle against a micro-step model.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BQ   = 7'b1100011;
    localparam logic [6:0] JL   = 7'b1101111;
    localparam logic [6:0] JLR  = 7'b1100111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal;
    logic [2:0] ALUControl;

    int n_pass  = 0;
    int n_total = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUControl(ALUControl),
        .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    // One micro-step of an instruction, as the controls it should present.
    typedef struct packed {
        logic [1:0] a, b, alu_op, rs;
        logic adr, irw, pcu, br, rw, mw, ill;
    } step_t;

    typedef struct packed {
        logic [1:0] imm, a, b, rs;
        logic adr, irw, pcw, rw, mw, ill;
        logic [2:0] aluc;
    } obs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         lat;
        logic [1:0] imm;
        logic [2:0] alu2;
        int         n_pcw, n_rw, n_mw, n_ill;
    } vec_t;

    step_t seq[$];
    vec_t  vecs[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic step_t mk(input logic [1:0] a, b, alu_op, rs,
                                 input logic adr, irw, pcu, br, rw, mw, ill);
        step_t s;
        s = '{a, b, alu_op, rs, adr, irw, pcu, br, rw, mw, ill};
        return s;
    endfunction

    function automatic bit known_op(input logic [6:0] o);
`ifdef JALR_SUPPORT_EN
        if (o == JLR) return 1'b1;
`endif
        return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BQ) || (o == JL);
    endfunction

    // Instruction -> list of micro-steps from the fetch through the last step.
    task automatic build(input logic [6:0] o);
        step_t wb;
        wb = mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0);
        seq.delete();
        seq.push_back(mk(2'b00, 2'b10, 2'b00, 2'b10, 0, 1, 1, 0, 0, 0, 0));
        seq.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, !known_op(o)));
        if (o == LW || o == SW) seq.push_back(mk(2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        if (o == LW) begin
            seq.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0));
            seq.push_back(mk(2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 1, 0, 0));
        end
        if (o == SW) seq.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 1, 0));
        if (o == RT) begin seq.push_back(mk(2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0)); seq.push_back(wb); end
        if (o == IT) begin seq.push_back(mk(2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0)); seq.push_back(wb); end
        if (o == BQ) seq.push_back(mk(2'b10, 2'b00, 2'b01, 2'b00, 0, 0, 0, 1, 0, 0, 0));
        if (o == JL) begin seq.push_back(mk(2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0)); seq.push_back(wb); end
`ifdef JALR_SUPPORT_EN
        if (o == JLR) begin
            seq.push_back(mk(2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
            seq.push_back(mk(2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0));
            seq.push_back(wb);
        end
`endif
    endtask

    function automatic obs_t exp_obs(input step_t s, input logic [6:0] o, input logic [2:0] f3,
                                     input logic f7, input logic z);
        obs_t e;
        e.imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
        e.a = s.a; e.b = s.b; e.rs = s.rs;
        e.adr = s.adr; e.irw = s.irw; e.rw = s.rw; e.mw = s.mw; e.ill = s.ill;
        e.pcw = s.pcu | (s.br & z);
        if (s.alu_op == 2'b01) e.aluc = 3'b001;
        else if (s.alu_op != 2'b10) e.aluc = 3'b000;
        else if (f3 == 3'b000) e.aluc = (o[5] && f7) ? 3'b001 : 3'b000;
        else if (f3 == 3'b010) e.aluc = 3'b101;
        else if (f3 == 3'b110) e.aluc = 3'b011;
        else if (f3 == 3'b111) e.aluc = 3'b010;
        else e.aluc = 3'b000;
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.imm = ImmSrc; o.a = ALUSrcA; o.b = ALUSrcB; o.rs = ResultSrc;
        o.adr = AdrSrc; o.irw = IRWrite; o.pcw = PCWrite; o.rw = RegWrite;
        o.mw = MemWrite; o.ill = Illegal; o.aluc = ALUControl;
        return o;
    endfunction

    // Runs one instruction from FETCH, comparing every cycle against the model.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input bit rand_z, input logic z, input string tag);
        build(o);
        op = o; funct3 = f3; funct7b5 = f7;
        foreach (seq[k]) begin
            Zero = rand_z ? 1'($urandom) : z;
            #1;
            check($sformatf("%s_step%0d", tag, k), 32'(sample()), 32'(exp_obs(seq[k], o, f3, f7, Zero)));
            tick();
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat, npc, nrw, nmw, nil;
        logic [1:0] imm;
        logic [2:0] alu2;
        lat = 0; npc = 0; nrw = 0; nmw = 0; nil = 0; imm = '0; alu2 = '0;
        op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.z;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c > 0 && IRWrite) begin
                lat = c;
                if (c == 2) alu2 = ALUControl;
                break;
            end
            if (c == 1) imm = ImmSrc;
            if (c == 2) alu2 = ALUControl;
            npc += int'(PCWrite); nrw += int'(RegWrite);
            nmw += int'(MemWrite); nil += int'(Illegal);
            tick();
        end
        check($sformatf("vec%0d_latency", idx), lat, v.lat);
        check($sformatf("vec%0d_immsrc", idx), 32'(imm), 32'(v.imm));
        check($sformatf("vec%0d_aluctl", idx), 32'(alu2), 32'(v.alu2));
        check($sformatf("vec%0d_pcwrite_cnt", idx), npc, v.n_pcw);
        check($sformatf("vec%0d_regwrite_cnt", idx), nrw, v.n_rw);
        check($sformatf("vec%0d_memwrite_cnt", idx), nmw, v.n_mw);
        check($sformatf("vec%0d_illegal_cnt", idx), nil, v.n_ill);
        if (lat == 0) begin
            reset = 1'b1; tick(); reset = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //          op    f3      f7    z     lat imm    alu2    pcw rw mw ill
        vecs[0]  = '{LW,  3'b010, 1'b0, 1'b0, 5, 2'b00, 3'b000, 1, 1, 0, 0};
        vecs[1]  = '{SW,  3'b010, 1'b0, 1'b0, 4, 2'b01, 3'b000, 1, 0, 1, 0};
        vecs[2]  = '{RT,  3'b000, 1'b1, 1'b0, 4, 2'b00, 3'b001, 1, 1, 0, 0};
        vecs[3]  = '{RT,  3'b010, 1'b0, 1'b0, 4, 2'b00, 3'b101, 1, 1, 0, 0};
        vecs[4]  = '{RT,  3'b111, 1'b0, 1'b1, 4, 2'b00, 3'b010, 1, 1, 0, 0};
        vecs[5]  = '{IT,  3'b000, 1'b1, 1'b0, 4, 2'b00, 3'b000, 1, 1, 0, 0};
        vecs[6]  = '{IT,  3'b110, 1'b0, 1'b0, 4, 2'b00, 3'b011, 1, 1, 0, 0};
        vecs[7]  = '{BQ,  3'b000, 1'b0, 1'b1, 3, 2'b10, 3'b001, 2, 0, 0, 0};
        vecs[8]  = '{BQ,  3'b000, 1'b0, 1'b0, 3, 2'b10, 3'b001, 1, 0, 0, 0};
        vecs[9]  = '{JL,  3'b000, 1'b0, 1'b0, 4, 2'b11, 3'b000, 2, 1, 0, 0};
`ifdef JALR_SUPPORT_EN
        vecs[10] = '{JLR, 3'b000, 1'b0, 1'b0, 5, 2'b00, 3'b000, 2, 1, 0, 0};
`else
        vecs[10] = '{JLR, 3'b000, 1'b0, 1'b0, 2, 2'b00, 3'b000, 1, 0, 0, 1};
`endif
        vecs[11] = '{7'b0000000, 3'b000, 1'b0, 1'b0, 2, 2'b00, 3'b000, 1, 0, 0, 1};

        reset = 1'b1; op = LW; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_irwrite",  32'(IRWrite),  1);
        check("rst_pcwrite",  32'(PCWrite),  1);
        check("rst_regwrite", 32'(RegWrite), 0);
        check("rst_memwrite", 32'(MemWrite), 0);
        check("rst_illegal",  32'(Illegal),  0);
        check("rst_srcb",     32'(ALUSrcB),  32'(2'b10));
        check("rst_result",   32'(ResultSrc), 32'(2'b10));

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Directed per-cycle sequences for the multi-cycle corner cases.
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        run_instr(LW, 3'b010, 1'b0, 1'b0, 1'b0, "lw");
        run_instr(SW, 3'b010, 1'b0, 1'b0, 1'b0, "sw");
        run_instr(BQ, 3'b000, 1'b0, 1'b0, 1'b1, "beq_z1");
        run_instr(BQ, 3'b000, 1'b0, 1'b0, 1'b0, "beq_z0");
        run_instr(RT, 3'b000, 1'b1, 1'b0, 1'b0, "sub");
        run_instr(IT, 3'b000, 1'b1, 1'b0, 1'b0, "addi");
        run_instr(JLR, 3'b000, 1'b0, 1'b0, 1'b0, "jalr");
        run_instr(JL, 3'b000, 1'b0, 1'b0, 1'b0, "jal");

        // Reset in MEMREAD of a lw: next cycle is FETCH with no register write.
        op = LW; funct3 = 3'b010; Zero = 1'b0;
        tick(); tick(); tick();
        #1;
        check("mr_adrsrc", 32'(AdrSrc), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mr_rst_irwrite",  32'(IRWrite),  1);
        check("mr_rst_regwrite", 32'(RegWrite), 0);
        check("mr_rst_srca",     32'(ALUSrcA),  0);
        tick();
        #1;
        check("mr_rst_decode_srca", 32'(ALUSrcA), 1);
        reset = 1'b1; tick(); reset = 1'b0;

        // Random instruction stream with Zero toggling every cycle.
        for (int n = 0; n < 300; n++) begin
            logic [6:0] o;
            case ($urandom_range(0, 7))
                0: o = LW;  1: o = SW;  2: o = RT;  3: o = IT;
                4: o = BQ;  5: o = JL;  6: o = JLR;
                default: o = 7'($urandom);
            endcase
            run_instr(o, 3'($urandom), 1'($urandom), 1'b1, 1'b0, $sformatf("rnd%0d", n));
        end
        #1;
        check("rnd_end_fetch", 32'(IRWrite), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
